mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Bus initiator between the multicycle processor's control FSM and the 64x16 unified memory. It drives the memory's 6-bit address, write data and active-low read/write strobes on behalf of four operations: LW, SW, LM and SM. LM and SM are multi-word transfers steered by an 8-bit register mask. It sequences one memory word per cycle. The block runs on the rising edge; the memory samples its strobes on the falling edge of the same clock.

## Interface
- No parameters. Widths are fixed: 6-bit address, 16-bit data, 8 registers.
- clk  in  1  single system clock; all state updates on posedge.
- proc_rst  in  1  asynchronous, active-low reset (same net that triggers the memory's program-image load).
- req  in  1  request strobe; accepted only when ready=1.
- op  in  2  00=LW, 01=SW, 10=LM, 11=SM.
- base_addr  in  6  first memory address of the transfer.
- mask  in  8  LM/SM register mask; bit i selects register i. Ignored for LW/SW.
- wr_data  in  16  SW store data.
- reg_rdata  in  16  register-file read data for reg_ridx (combinational, same cycle).
- ready  out  1  high in IDLE.
- done  out  1  one-cycle completion pulse.
- rd_data  out  16  LW result; holds until the next LW completes.
- reg_ridx  out  3  register index for the SM fetch.
- reg_we, reg_widx[2:0], reg_wdata[15:0]  out  LM register write port.
- mem_addr  out  6  memory address (registered).
- mem_wdata  out  16  memory write data (registered).
- mem_write_n, mem_read_n  out  1  active-low memory strobes (registered).

## Operation
- States: IDLE, READ, STORE_SETUP, STORE, FINISH.
- **IDLE, on req=1:**
  - Latch op, base_addr and mask.
  - Word pointer = base_addr.
  - Mask scan always runs in ascending bit order 0..7.
- **LW:** drive mem_read_n=0 and mem_addr=base for one cycle, then go to READ. At the next edge, capture the memory data into rd_data and pulse done.
- **SW:** drive mem_write_n=0, mem_addr=base and mem_wdata=wr_data for one cycle, then go to FINISH.
- **LM:** issue one read per set mask bit in consecutive cycles; the address increments per word.
  - Each captured word is presented one cycle after its strobe cycle: reg_we=1, reg_widx = its bit index, reg_wdata = the data.
  - done is asserted in the same cycle as the last reg_we.
- **SM:**
  - STORE_SETUP presents reg_ridx = the first set bit.
  - STORE registers reg_rdata into mem_wdata with mem_write_n=0, one word per cycle, while advancing reg_ridx.
  - After the last word, go to FINISH.
- **FINISH:** pulse done, return to IDLE.
- **Mask = 0 (LM/SM):** no strobes; done pulses in the cycle after acceptance.
- **Address arithmetic:** 6-bit modulo; 63 + 1 wraps to 0.
- **Strobe exclusivity:** mem_read_n and mem_write_n are never low in the same cycle.
- **req while ready=0:** ignored, not queued.

## Timing
- **Reset values (asynchronous, proc_rst=0):**
  - state=IDLE, ready=1, done=0, reg_we=0.
  - mem_read_n=1, mem_write_n=1.
  - mem_addr=0, mem_wdata=0, rd_data=0, reg_widx=0, reg_wdata=0, reg_ridx=0.
  - Strobes must be high during reset so the memory's image load is not overwritten.
- **Reset mid-transfer:** abort immediately; no further strobes; no done pulse.
- Let E0 be the acceptance edge. Outputs registered at E0 are visible in the cycle E0..E1.

| Op | Strobes low | Other outputs | done |
|---|---|---|---|
| LW | mem_read_n: E0..E1 | rd_data valid from E1 | E1..E2 |
| SW | mem_write_n: E0..E1 | — | E1..E2 |
| LM (N≥1 set bits) | mem_read_n: E0..EN | reg_we: E1..E(N+1) | with last reg_we |
| SM (N≥1 set bits) | mem_write_n: E1..E(N+1) | — | E(N+1)..E(N+2) |
| LM/SM, mask=0 | none | — | E0..E1 |

- **Throughput:** one word per cycle. ready returns to 1 in the cycle after done.

## Test plan
- **Reset + LW:** proc_rst pulse, program image loaded; LW base=23 → mem_read_n low for 1 cycle, rd_data=16'h0003, done one cycle after the strobe; mem_write_n stays 1 throughout.
- **SW then LW:** SW base=40, wr_data=16'hBEEF → single write strobe with addr 40 and data BEEF; then LW base=40 → rd_data=16'hBEEF.
- **LM sparse mask:** LM base=2, mask=8'b1010_0101, memory preloaded so word k at address 2+k holds 16'h0010+k → reg_we on 4 consecutive cycles with (idx,data) = (0,0010), (2,0011), (5,0012), (7,0013); done aligned with the last reg_we.
- **SM with wrap:** SM base=62, mask=8'hFF, reg i = 16'h0100+i → writes to addresses 62, 63, 0, 1, ..., 5 with data 0100..0107; 8 consecutive strobe cycles.
- **Empty mask and busy req:** LM mask=0 → done in the next cycle, no strobes. During an 8-word SM, pulse req with op=LW → ignored; exactly one done.
- **Reset mid-LM:** assert proc_rst after 3 of 8 reads → strobes go high immediately, reg_we=0, no done; after release, ready=1 and a new LW completes normally.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Memory bus initiator for LW/SW/LM/SM; one word per cycle, strobes registered on posedge for a negedge-sampling memory.
// Latency: LW/SW done 1 cycle after accept, LM with last reg write, SM N+1 cycles; req is accepted only while ready=1, never queued.
module mem_access_ctrl (
  input  logic        clk,
  input  logic        proc_rst,
  input  logic        req,
  input  logic [1:0]  op,
  input  logic [5:0]  base_addr,
  input  logic [7:0]  mask,
  input  logic [15:0] wr_data,
  input  logic [15:0] reg_rdata,
  input  logic [15:0] mem_rdata,
  output logic        ready,
  output logic        done,
  output logic [15:0] rd_data,
  output logic [2:0]  reg_ridx,
  output logic        reg_we,
  output logic [2:0]  reg_widx,
  output logic [15:0] reg_wdata,
  output logic [5:0]  mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_write_n,
  output logic        mem_read_n
);

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_READ        = 3'd1;
  localparam logic [2:0] S_STORE_SETUP = 3'd2;
  localparam logic [2:0] S_STORE       = 3'd3;
  localparam logic [2:0] S_FINISH      = 3'd4;

  localparam logic [1:0] OP_LW = 2'b00;
  localparam logic [1:0] OP_SW = 2'b01;
  localparam logic [1:0] OP_LM = 2'b10;
  localparam logic [1:0] OP_SM = 2'b11;

  logic [2:0] state;
  logic [1:0] op_q;
  logic [7:0] rem;
  logic [5:0] ptr;
  logic [2:0] widx_q;

  function automatic logic [2:0] first_bit(input logic [7:0] m);
    first_bit = '0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) first_bit = i[2:0];
    end
  endfunction

  // done is held back one cycle from ready so a new req cannot overlap the completion pulse
  assign ready = (state == S_IDLE) && !done;

  always_ff @(posedge clk or negedge proc_rst) begin
    if (!proc_rst) begin
      state       <= S_IDLE;
      op_q        <= OP_LW;
      rem         <= '0;
      ptr         <= '0;
      widx_q      <= '0;
      done        <= 1'b0;
      rd_data     <= '0;
      reg_ridx    <= '0;
      reg_we      <= 1'b0;
      reg_widx    <= '0;
      reg_wdata   <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_write_n <= 1'b1;
      mem_read_n  <= 1'b1;
    end else begin
      done        <= 1'b0;
      reg_we      <= 1'b0;
      mem_read_n  <= 1'b1;
      mem_write_n <= 1'b1;
      case (state)
        S_IDLE: begin
          if (req && ready) begin
            op_q <= op;
            case (op)
              OP_LW: begin
                mem_read_n <= 1'b0;
                mem_addr   <= base_addr;
                state      <= S_READ;
              end
              OP_SW: begin
                mem_write_n <= 1'b0;
                mem_addr    <= base_addr;
                mem_wdata   <= wr_data;
                state       <= S_FINISH;
              end
              OP_LM: begin
                if (mask == 8'd0) begin
                  done <= 1'b1;
                end else begin
                  mem_read_n <= 1'b0;
                  mem_addr   <= base_addr;
                  widx_q     <= first_bit(mask);
                  rem        <= mask & (mask - 8'd1);
                  state      <= S_READ;
                end
              end
              default: begin
                if (mask == 8'd0) begin
                  done <= 1'b1;
                end else begin
                  reg_ridx <= first_bit(mask);
                  rem      <= mask & (mask - 8'd1);
                  ptr      <= base_addr;
                  state    <= S_STORE_SETUP;
                end
              end
            endcase
          end
        end
        S_READ: begin
          if (op_q == OP_LW) begin
            rd_data <= mem_rdata;
            done    <= 1'b1;
            state   <= S_IDLE;
          end else begin
            reg_we    <= 1'b1;
            reg_widx  <= widx_q;
            reg_wdata <= mem_rdata;
            if (rem != 8'd0) begin
              mem_read_n <= 1'b0;
              mem_addr   <= mem_addr + 6'd1;
              widx_q     <= first_bit(rem);
              rem        <= rem & (rem - 8'd1);
            end else begin
              done  <= 1'b1;
              state <= S_IDLE;
            end
          end
        end
        // the register file answers reg_ridx combinationally, so each cycle stores one word
        S_STORE_SETUP, S_STORE: begin
          mem_write_n <= 1'b0;
          mem_addr    <= ptr;
          mem_wdata   <= reg_rdata;
          ptr         <= ptr + 6'd1;
          if (rem != 8'd0) begin
            reg_ridx <= first_bit(rem);
            rem      <= rem & (rem - 8'd1);
            state    <= S_STORE;
          end else begin
            state <= S_FINISH;
          end
        end
        S_FINISH: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized scoreboard bench for mem_access_ctrl with a negedge-sampling 64x16 memory and an 8-entry register file.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        proc_rst = 1'b1;
  logic        req = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [5:0]  base_addr = '0;
  logic [7:0]  mask = '0;
  logic [15:0] wr_data = '0;
  logic [15:0] reg_rdata;
  logic [15:0] mem_rdata;
  logic        ready, done, reg_we, mem_write_n, mem_read_n;
  logic [15:0] rd_data, reg_wdata, mem_wdata;
  logic [2:0]  reg_ridx, reg_widx;
  logic [5:0]  mem_addr;

  mem_access_ctrl dut (
    .clk(clk), .proc_rst(proc_rst), .req(req), .op(op), .base_addr(base_addr),
    .mask(mask), .wr_data(wr_data), .reg_rdata(reg_rdata), .mem_rdata(mem_rdata),
    .ready(ready), .done(done), .rd_data(rd_data), .reg_ridx(reg_ridx),
    .reg_we(reg_we), .reg_widx(reg_widx), .reg_wdata(reg_wdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write_n(mem_write_n),
    .mem_read_n(mem_read_n)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [5:0] addr; logic [15:0] data; } wr_t;
  typedef struct packed { logic [2:0] idx; logic [15:0] data; logic last; } rw_t;

  int checks = 0;
  int errors = 0;
  bit sb_off = 1'b0;

  logic [5:0]  rdq[$];
  wr_t         wrq[$];
  rw_t         rwq[$];
  logic [15:0] doneq[$];

  logic [15:0] ref_mem [64];
  logic [15:0] ref_rf [8];
  logic [15:0] last_lw;

  logic [15:0] mem [64];
  logic [15:0] rf [8];
  assign reg_rdata = rf[reg_ridx];

  function automatic logic [15:0] img(input int i);
    if (i == 23) return 16'h0003;
    if (i >= 2 && i <= 5) return 16'h0010 + 16'(i - 2);
    return 16'hA000 ^ 16'(i * 37);
  endfunction

  // Memory: loads its image while proc_rst is low, samples strobes on the falling edge
  always @(negedge clk) begin
    if (!proc_rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= img(i);
      mem_rdata <= '0;
    end else begin
      if (!mem_write_n) mem[mem_addr] <= mem_wdata;
      if (!mem_read_n) mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s actual=%0h required=none", name, act);
  endtask

  task automatic reset_model();
    for (int i = 0; i < 64; i++) ref_mem[i] = img(i);
    for (int i = 0; i < 8; i++) ref_rf[i] = 16'h0100 + 16'(i);
    last_lw = '0;
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!proc_rst) begin
        for (int i = 0; i < 8; i++) rf[i] = 16'h0100 + 16'(i);
      end else if (!sb_off) begin
        if (!mem_read_n || !mem_write_n)
          chk("strobe_excl", {31'b0, mem_read_n | mem_write_n}, 32'd1);
        if (!mem_read_n) begin
          if (rdq.size() == 0) unexpected("read_strobe", {26'b0, mem_addr});
          else begin
            logic [5:0] ea;
            ea = rdq.pop_front();
            chk("read_addr", {26'b0, mem_addr}, {26'b0, ea});
          end
        end
        if (!mem_write_n) begin
          if (wrq.size() == 0) unexpected("write_strobe", {26'b0, mem_addr});
          else begin
            wr_t ew;
            ew = wrq.pop_front();
            chk("write_addr", {26'b0, mem_addr}, {26'b0, ew.addr});
            chk("write_data", {16'b0, mem_wdata}, {16'b0, ew.data});
          end
        end
        if (reg_we) begin
          if (rwq.size() == 0) unexpected("reg_we", {29'b0, reg_widx});
          else begin
            rw_t er;
            er = rwq.pop_front();
            chk("reg_widx", {29'b0, reg_widx}, {29'b0, er.idx});
            chk("reg_wdata", {16'b0, reg_wdata}, {16'b0, er.data});
            chk("lm_done_align", {31'b0, done}, {31'b0, er.last});
          end
          rf[reg_widx] = reg_wdata;
        end
        if (done) begin
          if (doneq.size() == 0) unexpected("done_pulse", 32'd1);
          else begin
            logic [15:0] ed;
            ed = doneq.pop_front();
            chk("rd_data", {16'b0, rd_data}, {16'b0, ed});
          end
        end
      end
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [5:0] b, input logic [7:0] m,
                       input logic [15:0] wd, input bit poke);
    int n, lat, exp_lat, cnt, k;
    logic [5:0] a;
    wr_t ew;
    rw_t er;
    n = 0;
    @(negedge clk);
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready) unexpected("ready_timeout", 32'(n));
    a = b;
    cnt = $countones(m);
    k = 0;
    exp_lat = 1;
    case (o)
      2'b00: begin
        rdq.push_back(b);
        last_lw = ref_mem[b];
      end
      2'b01: begin
        ew.addr = b; ew.data = wd;
        wrq.push_back(ew);
        ref_mem[b] = wd;
      end
      2'b10: begin
        for (int i = 0; i < 8; i++) if (m[i]) begin
          k++;
          rdq.push_back(a);
          er.idx = 3'(i); er.data = ref_mem[a]; er.last = (k == cnt);
          rwq.push_back(er);
          ref_rf[i] = ref_mem[a];
          a = a + 6'd1;
        end
        exp_lat = cnt;
      end
      default: begin
        for (int i = 0; i < 8; i++) if (m[i]) begin
          ew.addr = a; ew.data = ref_rf[i];
          wrq.push_back(ew);
          ref_mem[a] = ref_rf[i];
          a = a + 6'd1;
        end
        exp_lat = (cnt == 0) ? 0 : cnt + 1;
      end
    endcase
    doneq.push_back(last_lw);
    op = o; base_addr = b; mask = m; wr_data = wd; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    lat = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (poke && c == 1) begin
        req = 1'b1; op = 2'b00; base_addr = 6'd7;
      end
      if (poke && c == 2) req = 1'b0;
      if (done) begin
        lat = c;
        break;
      end
    end
    chk("latency", 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    fork
      monitor();
    join_none
    reset_model();
    #1 proc_rst = 1'b0;
    #2;
    chk("rst_ready", {31'b0, ready}, 32'd1);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_reg_we", {31'b0, reg_we}, 32'd0);
    chk("rst_strobes", {30'b0, mem_read_n, mem_write_n}, 32'd3);
    chk("rst_addr_data", {10'b0, mem_addr, mem_wdata}, 32'd0);
    chk("rst_rd_data", {16'b0, rd_data}, 32'd0);
    chk("rst_reg_ports", {7'b0, reg_ridx, reg_widx, reg_wdata}, 32'd0);
    repeat (2) @(negedge clk);
    proc_rst = 1'b1;

    issue(2'b00, 6'd23, 8'h00, 16'h0000, 1'b0);
    issue(2'b01, 6'd40, 8'h00, 16'hBEEF, 1'b0);
    issue(2'b00, 6'd40, 8'h00, 16'h0000, 1'b0);
    issue(2'b10, 6'd2, 8'b1010_0101, 16'h0000, 1'b0);

    // fresh image and register file for the wrapping store
    @(negedge clk);
    proc_rst = 1'b0;
    repeat (2) @(negedge clk);
    proc_rst = 1'b1;
    reset_model();
    issue(2'b11, 6'd62, 8'hFF, 16'h0000, 1'b1);
    issue(2'b10, 6'd9, 8'h00, 16'h0000, 1'b0);
    issue(2'b11, 6'd0, 8'h00, 16'h0000, 1'b0);

    // abort an 8-word LM after its third read
    @(negedge clk);
    sb_off = 1'b1;
    op = 2'b10; base_addr = 6'd10; mask = 8'hFF; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    repeat (3) @(posedge clk);
    #2 proc_rst = 1'b0;
    #1;
    chk("abort_strobes", {30'b0, mem_read_n, mem_write_n}, 32'd3);
    chk("abort_reg_we", {31'b0, reg_we}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    repeat (2) @(negedge clk);
    proc_rst = 1'b1;
    reset_model();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_abort_done", {31'b0, done}, 32'd0);
      chk("post_abort_ready", {31'b0, ready}, 32'd1);
    end
    sb_off = 1'b0;
    issue(2'b00, 6'd62, 8'h00, 16'h0000, 1'b0);

    for (int t = 0; t < 150; t++) begin
      logic [7:0] m;
      m = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      issue(2'($urandom), 6'($urandom), m, 16'($urandom), 1'b0);
    end

    repeat (5) @(negedge clk);
    chk("left_reads", 32'(rdq.size()), 32'd0);
    chk("left_writes", 32'(wrq.size()), 32'd0);
    chk("left_reg_writes", 32'(rwq.size()), 32'd0);
    chk("left_dones", 32'(doneq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
